// File: rtl/descrambler_sync.sv
// Self-synchronous x^POLY_LEN + x^TAP + 1 scrambler/descrambler with valid handshake,
// bypass, seed load and a priming FSM that flags when descrambler history is all real data.
module descrambler_sync #(
  parameter int unsigned          WIDTH    = 64,
  parameter int unsigned          POLY_LEN = 58,
  parameter int unsigned          TAP      = 39,
  parameter logic [POLY_LEN-1:0]  INIT     = {POLY_LEN{1'b1}}
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                mode_scram,
  input  logic                bypass,
  input  logic                seed_load,
  input  logic [POLY_LEN-1:0] seed,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    din,
  output logic                out_valid,
  output logic [WIDTH-1:0]    dout,
  output logic                primed
);

  localparam int unsigned         HW        = WIDTH + POLY_LEN;
  localparam int unsigned         FILL_W    = $clog2(POLY_LEN + 1);
  localparam logic [FILL_W-1:0]   FILL_FULL = FILL_W'(POLY_LEN);

  typedef enum logic {
    ST_FILL   = 1'b0,
    ST_PRIMED = 1'b1
  } prime_state_e;

  logic [POLY_LEN-1:0] state_q, state_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  prime_state_e        fsm_q, fsm_d;
  logic                mode_q, mode_d;
  logic [WIDTH-1:0]    dout_q, dout_d;
  logic                primed_q, primed_d;
  logic                out_valid_q;

  logic [POLY_LEN-1:0] cur_state;
  logic [HW-1:0]       h;
  logic [WIDTH-1:0]    desc_word;
  logic [POLY_LEN-1:0] desc_next;
  logic [HW-1:0]       s;
  logic [WIDTH-1:0]    scr_word;
  logic [POLY_LEN-1:0] scr_next;
  logic                mode_chg;

  assign cur_state = seed_load ? seed : state_q;

  // Descrambler: history is the received line bits, so every output bit is independent.
  assign h         = {din, cur_state};
  assign desc_next = h[HW-1:WIDTH];

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_desc
    assign desc_word[gi] = h[POLY_LEN + gi] ^ h[gi] ^ h[POLY_LEN + gi - TAP];
  end

  // Scrambler: history is the transmitted bits, so each bit feeds later bits of the same word.
  always_comb begin
    s = {{WIDTH{1'b0}}, cur_state};
    for (int i = 0; i < WIDTH; i++) begin
      s[POLY_LEN + i] = din[i] ^ s[i] ^ s[POLY_LEN + i - TAP];
    end
  end

  assign scr_word = s[HW-1:POLY_LEN];
  assign scr_next = s[HW-1:WIDTH];
  assign mode_chg = (mode_scram != mode_q);

  logic [FILL_W-1:0] fill_base;
  prime_state_e      fsm_base;
  logic [31:0]       fill_sum;

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    fsm_d     = fsm_q;
    mode_d    = mode_q;
    dout_d    = dout_q;
    primed_d  = primed_q;
    fill_base = '0;
    fsm_base  = ST_FILL;
    fill_sum  = '0;

    if (bypass) begin
      if (in_valid) begin
        dout_d   = din;
        primed_d = 1'b1;
      end
    end else if (in_valid) begin
      mode_d    = mode_scram;
      dout_d    = mode_scram ? scr_word : desc_word;
      state_d   = mode_scram ? scr_next : desc_next;
      fill_base = mode_chg ? '0 : fill_q;
      fsm_base  = mode_chg ? ST_FILL : fsm_q;
      fill_sum  = 32'(fill_base) + WIDTH;
      fill_d    = fill_base;
      fsm_d     = fsm_base;
      if (seed_load) begin
        fsm_d    = ST_PRIMED;
        fill_d   = FILL_FULL;
        primed_d = 1'b1;
      end else if (mode_scram) begin
        fsm_d    = ST_PRIMED;
        primed_d = 1'b1;
      end else if (fsm_base == ST_PRIMED) begin
        primed_d = 1'b1;
      end else begin
        // The word that completes the history is still built on partly unknown bits.
        primed_d = 1'b0;
        fill_d   = (fill_sum >= POLY_LEN) ? FILL_FULL : fill_sum[FILL_W-1:0];
        if (fill_sum >= POLY_LEN) begin
          fsm_d = ST_PRIMED;
        end
      end
    end else if (seed_load) begin
      state_d = seed;
      fsm_d   = ST_PRIMED;
      fill_d  = FILL_FULL;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= INIT;
      fill_q      <= '0;
      fsm_q       <= ST_FILL;
      mode_q      <= 1'b0;
      dout_q      <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      fsm_q       <= fsm_d;
      mode_q      <= mode_d;
      dout_q      <= dout_d;
      primed_q    <= primed_d;
      out_valid_q <= in_valid;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign primed    = primed_q;

endmodule
